// File: rtl/onchip_mem_arb_pkg.sv
// rtl/onchip_mem_arb_pkg.sv - shared defaults and helpers for the on-chip RAM arbiter
package onchip_mem_arb_pkg;

   localparam int DEF_NUM_MASTERS = 4;
   localparam int DEF_ADDR_W      = 17;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_HOLD_MAX    = 4;

   // Hold counter width; HOLD_MAX is limited to 15
   localparam int HOLD_W = 4;

   // Ceiling log2, never less than 1 so index vectors stay legal
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   localparam int DEF_IDX_W = clog2(DEF_NUM_MASTERS);

endpackage

// File: rtl/onchip_mem_rr_arbiter_rr_pick.sv
// rtl/onchip_mem_rr_arbiter_rr_pick.sv - combinational rotating priority encoder
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] base_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // First requester found scanning upward from base_i, wrapping at N
   always_comb begin
      int cand;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         cand = int'(base_i) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/onchip_mem_rr_arbiter.sv
// rtl/onchip_mem_rr_arbiter.sv - round-robin sharing of one single-port RAM among Avalon-MM masters
module onchip_mem_rr_arbiter
   import onchip_mem_arb_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int HOLD_MAX    = DEF_HOLD_MAX
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
   input  logic [NUM_MASTERS-1:0]          m_read,
   input  logic [NUM_MASTERS-1:0]          m_write,
   output logic [NUM_MASTERS-1:0]          m_waitrequest,
   output logic [NUM_MASTERS-1:0]          m_readdatavalid,
   output logic [DATA_W-1:0]               m_readdata,
   output logic [ADDR_W-1:0]               mem_address,
   output logic [DATA_W/8-1:0]             mem_byteenable,
   output logic [DATA_W-1:0]               mem_writedata,
   output logic                            mem_chipselect,
   output logic                            mem_write,
   output logic                            mem_clken,
   input  logic [DATA_W-1:0]               mem_readdata
);

   localparam int IDX_W = clog2(NUM_MASTERS);
   localparam int BE_W  = DATA_W / 8;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] grant;
   logic [NUM_MASTERS-1:0] pick_grant;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;
   logic [IDX_W-1:0]       base;
   logic                   keep;
   logic [IDX_W-1:0]       win_idx;
   logic                   win_any;
   logic [IDX_W-1:0]       sel;

   logic [IDX_W-1:0]  owner_q, owner_d;
   logic              owner_vld_q, owner_vld_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic [IDX_W-1:0]  rd_id_q, rd_id_d;

   // A master asserting read and write together is a write, so either bit is a request
   assign req = m_read | m_write;

   // Rotation starts just after the most recently granted master
   always_comb begin
      base = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
   end

   rr_pick #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (req),
      .base_i  (base),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Owner keeps the port while it still asks and its hold budget is not spent
   always_comb begin
      keep    = owner_vld_q && req[owner_q] && (hold_cnt_q < HOLD_LIM);
      win_idx = keep ? owner_q : pick_idx;
      win_any = reset_n && (keep || (pick_any && (pick_grant != '0)));
   end

   // One-hot grant of the winner; nobody is granted while reset is held
   always_comb begin
      grant = '0;
      if (win_any) begin
         grant[win_idx] = 1'b1;
      end
   end

   // Losers that request are stalled; idle masters never see waitrequest
   always_comb begin
      if (!reset_n) begin
         m_waitrequest = '1;
      end else begin
         m_waitrequest = req & ~grant;
      end
   end

   // Route the winning master onto the RAM port; master 0 is parked there when idle
   always_comb begin
      sel            = win_any ? win_idx : '0;
      mem_address    = m_address[sel*ADDR_W +: ADDR_W];
      mem_byteenable = m_byteenable[sel*BE_W +: BE_W];
      mem_writedata  = m_writedata[sel*DATA_W +: DATA_W];
      mem_chipselect = win_any;
      mem_write      = win_any && m_write[win_idx];
      mem_clken      = reset_n;
   end

   // Read data is shared; the per-master valid tags whose read came back
   always_comb begin
      m_readdata      = mem_readdata;
      m_readdatavalid = '0;
      if (rd_pend_q) begin
         m_readdatavalid[rd_id_q] = 1'b1;
      end
   end

   // Hold/owner bookkeeping and capture of the accepted read for the return cycle
   always_comb begin
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      last_d      = last_q;
      hold_cnt_d  = hold_cnt_q;
      rd_pend_d   = 1'b0;
      rd_id_d     = rd_id_q;
      if (win_any) begin
         if (owner_vld_q && (win_idx == owner_q)) begin
            if (hold_cnt_q < HOLD_LIM) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end else begin
            hold_cnt_d  = HOLD_W'(1);
            owner_d     = win_idx;
            owner_vld_d = 1'b1;
            last_d      = win_idx;
         end
         rd_pend_d = !m_write[win_idx];
         rd_id_d   = win_idx;
      end else begin
         hold_cnt_d  = '0;
         owner_vld_d = 1'b0;
      end
   end

   // State registers; reset gives master 0 first priority and drops any pending read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
         last_q      <= LAST_IDX;
         hold_cnt_q  <= '0;
         rd_pend_q   <= 1'b0;
         rd_id_q     <= '0;
      end else begin
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         rd_pend_q   <= rd_pend_d;
         rd_id_q     <= rd_id_d;
      end
   end

endmodule

// File: tb/tb_onchip_mem_rr_arbiter.sv
// tb/tb_onchip_mem_rr_arbiter.sv - self-checking bench for onchip_mem_rr_arbiter
module tb_onchip_mem_rr_arbiter;

   localparam int N   = 4;
   localparam int AW  = 17;
   localparam int DW  = 32;
   localparam int HM  = 4;
   localparam int MAX_WAIT = (N - 1) * HM;

   logic clk = 1'b0;
   logic reset_n;

   logic [N*AW-1:0]   m_address;
   logic [N*DW/8-1:0] m_byteenable;
   logic [N*DW-1:0]   m_writedata;
   logic [N-1:0]      m_read;
   logic [N-1:0]      m_write;
   logic [N-1:0]      m_waitrequest;
   logic [N-1:0]      m_readdatavalid;
   logic [DW-1:0]     m_readdata;
   logic [AW-1:0]     mem_address;
   logic [DW/8-1:0]   mem_byteenable;
   logic [DW-1:0]     mem_writedata;
   logic              mem_chipselect;
   logic              mem_write;
   logic              mem_clken;
   logic [DW-1:0]     mem_readdata = '0;

   logic [AW-1:0] a  [N];
   logic [3:0]    be [N];
   logic [31:0]   wd [N];
   logic [N-1:0]  rd;
   logic [N-1:0]  wr;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } rd_exp_t;
   rd_exp_t sbq[$];

   typedef struct {
      logic [3:0] rd;
      logic [3:0] wr;
      int         gnt;
   } vec_t;
   vec_t tbl[$];

   logic [31:0] ram [0:131071];
   bit          ram_vld [0:131071];
   logic [31:0] shadow [0:131071];
   bit          shadow_vld [0:131071];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int wait_cnt [N];
   int last_w;
   logic [N-1:0]  last_wait;
   logic [N-1:0]  last_rdv;
   logic [N-1:0]  last_acc;
   logic [31:0]   last_rdata;

   always #5 clk = ~clk;

   onchip_mem_rr_arbiter #(
      .NUM_MASTERS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .HOLD_MAX    (HM)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .m_address       (m_address),
      .m_byteenable    (m_byteenable),
      .m_writedata     (m_writedata),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_waitrequest   (m_waitrequest),
      .m_readdatavalid (m_readdatavalid),
      .m_readdata      (m_readdata),
      .mem_address     (mem_address),
      .mem_byteenable  (mem_byteenable),
      .mem_writedata   (mem_writedata),
      .mem_chipselect  (mem_chipselect),
      .mem_write       (mem_write),
      .mem_clken       (mem_clken),
      .mem_readdata    (mem_readdata)
   );

   always_comb begin
      for (int i = 0; i < N; i++) begin
         m_address[i*AW +: AW]  = a[i];
         m_byteenable[i*4 +: 4] = be[i];
         m_writedata[i*DW +: DW] = wd[i];
      end
      m_read  = rd;
      m_write = wr;
   end

   function automatic logic [31:0] init_word(input logic [AW-1:0] adr);
      return 32'hC0DE_0000 ^ (32'(adr) * 32'h0009_E377);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] ben);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
      end
      return r;
   endfunction

   // Single-port RAM model with one cycle of read latency
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            ram[mem_address]     <= merge(ram_vld[mem_address] ? ram[mem_address] : init_word(mem_address),
                                          mem_writedata, mem_byteenable);
            ram_vld[mem_address] <= 1'b1;
         end else begin
            mem_readdata <= ram_vld[mem_address] ? ram[mem_address] : init_word(mem_address);
         end
      end
   end

   function automatic logic [31:0] model_word(input logic [AW-1:0] adr);
      return shadow_vld[adr] ? shadow[adr] : init_word(adr);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic monitor();
      logic [N-1:0] req;
      logic [N-1:0] acc;
      logic [N-1:0] exp_rdv;
      logic [31:0]  exp_data;
      int w;
      req        = rd | wr;
      acc        = reset_n ? (req & ~m_waitrequest) : '0;
      last_w     = -1;
      last_wait  = m_waitrequest;
      last_rdv   = m_readdatavalid;
      last_rdata = m_readdata;
      last_acc   = acc;
      exp_rdv    = '0;
      exp_data   = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         exp_rdv[sbq[0].id] = 1'b1;
         exp_data = sbq[0].data;
         void'(sbq.pop_front());
      end
      check("readdatavalid", m_readdatavalid, exp_rdv);
      if (exp_rdv != '0) check("readdata", m_readdata, exp_data);
      if (!reset_n) begin
         check("rst_waitrequest", m_waitrequest, {N{1'b1}});
         check("rst_clken", mem_clken, 0);
         check("rst_chipselect", mem_chipselect, 0);
      end else begin
         check("grant_count", 64'($countones(acc)), (req != '0) ? 64'd1 : 64'd0);
         check("idle_waitrequest", m_waitrequest & ~req, 0);
         check("chipselect", mem_chipselect, (acc != '0) ? 64'd1 : 64'd0);
         check("clken", mem_clken, 1);
         w = -1;
         for (int i = 0; i < N; i++) if (acc[i]) w = i;
         if (w >= 0) begin
            last_w = w;
            check("mem_address", mem_address, a[w]);
            check("mem_write", mem_write, wr[w]);
            if (wr[w]) begin
               check("mem_byteenable", mem_byteenable, be[w]);
               check("mem_writedata", mem_writedata, wd[w]);
               shadow[a[w]]     = merge(model_word(a[w]), wd[w], be[w]);
               shadow_vld[a[w]] = 1'b1;
            end else begin
               sbq.push_back('{w, model_word(a[w]), cyc + 1});
            end
            for (int i = 0; i < N; i++) begin
               if (i != w && req[i]) begin
                  wait_cnt[i]++;
                  check("max_wait", (wait_cnt[i] <= MAX_WAIT) ? 64'd1 : 64'd0, 1);
               end
            end
            wait_cnt[w] = 0;
         end else begin
            check("mem_write_idle", mem_write, 0);
         end
         for (int i = 0; i < N; i++) if (!req[i]) wait_cnt[i] = 0;
      end
   endtask

   // Inputs are set just after a rising edge; outputs are sampled one unit later
   task automatic step();
      #1;
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rd = '0;
      wr = '0;
      reset_n = 1'b0;
      sbq.delete();
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      int r;
      logic [31:0] w_hi;

      // Arbitration vectors starting from reset: all four write continuously, then corners
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < HM; k++) tbl.push_back('{4'h0, 4'hF, g});
      tbl.push_back('{4'h0, 4'hF, 0});
      for (int k = 0; k < 4; k++) tbl.push_back('{4'h0, 4'h1, 0});
      tbl.push_back('{4'h0, 4'hF, 1});
      tbl.push_back('{4'h0, 4'h0, -1});
      tbl.push_back('{4'h5, 4'h0, 2});
      tbl.push_back('{4'h5, 4'h0, 2});
      tbl.push_back('{4'h0, 4'h0, -1});

      for (int i = 0; i < N; i++) begin
         a[i] = '0; be[i] = 4'hF; wd[i] = '0; wait_cnt[i] = 0;
      end
      rd = '0;
      wr = '0;
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;

      // Master 0 reads 0x10 three cycles back to back
      rd[0] = 1'b1;
      a[0]  = 17'h00010;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t1_waitrequest", last_wait[0], 0);
      end
      rd[0] = 1'b0;
      step();
      check("t1_last_rdv", last_rdv, 4'b0001);
      check("t1_last_data", last_rdata, init_word(17'h00010));

      // Table-driven arbitration sequence
      do_reset();
      foreach (tbl[t]) begin
         rd = tbl[t].rd;
         wr = tbl[t].wr;
         for (int i = 0; i < N; i++) begin
            a[i] = 17'(32 + i); be[i] = 4'hF; wd[i] = 32'(t * 16 + i);
         end
         step();
         check("tbl_grant", last_w, tbl[t].gnt);
      end

      // Partial write at the top address, then read back by another master
      wr[2] = 1'b1; a[2] = 17'h1FFFF; wd[2] = 32'hDEADBEEF; be[2] = 4'b0011;
      step();
      check("t3_write_grant", last_w, 2);
      wr[2] = 1'b0;
      rd[1] = 1'b1; a[1] = 17'h1FFFF;
      step();
      check("t3_read_grant", last_w, 1);
      rd[1] = 1'b0;
      step();
      w_hi = init_word(17'h1FFFF);
      check("t3_rdv", last_rdv, 4'b0010);
      check("t3_data", last_rdata, {w_hi[31:16], 16'hBEEF});

      // Simultaneous requests from masters 1 and 3 straight after reset
      do_reset();
      rd[1] = 1'b1; a[1] = 17'd5;
      rd[3] = 1'b1; a[3] = 17'd6;
      step();
      check("t4_first", last_w, 1);
      check("t4_wait3", last_wait[3], 1);
      rd[1] = 1'b0;
      step();
      check("t4_second", last_w, 3);
      rd[3] = 1'b0;
      step();

      // Reset arrives the cycle after a read is accepted
      wr[1] = 1'b1; a[1] = 17'd7; wd[1] = 32'h1234_5678; be[1] = 4'hF;
      step();
      wr[1] = 1'b0;
      rd[0] = 1'b1; a[0] = 17'd8;
      step();
      check("t5_read_grant", last_w, 0);
      reset_n = 1'b0;
      rd[0] = 1'b0;
      sbq.delete();
      step();
      check("t5_no_rdv", last_rdv, 0);
      step();
      check("t5_no_rdv_late", last_rdv, 0);
      reset_n = 1'b1;
      wr = 4'hF;
      step();
      check("t5_priority", last_w, 0);
      wr = '0;
      step();

      // Random traffic; each master holds its request until accepted
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(rd[i] | wr[i]) || last_acc[i]) begin
               r = $urandom_range(0, 9);
               rd[i] = 1'b0;
               wr[i] = 1'b0;
               if (r < 4) rd[i] = 1'b1;
               else if (r < 7) wr[i] = 1'b1;
               else if (r == 7) begin rd[i] = 1'b1; wr[i] = 1'b1; end
               a[i]  = 17'($urandom_range(0, 15));
               be[i] = 4'($urandom_range(1, 15));
               wd[i] = $urandom();
            end
         end
         step();
      end
      rd = '0;
      wr = '0;
      step();
      step();
      check("sb_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
